imem_boot_sequencer: RTL and testbench

IMEM_BOOT_SEQUENCER -- requirements
Module: imem_boot_sequencer

---
 rtl/imem_boot_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_imem_boot_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_sequencer.sv
// ---------------------------------------------------------------------------
// imem_boot_sequencer
//
// Streams a program from a host into the instruction memory, then holds the
// pipeline core in reset for a few cycles before letting it run. While in RUN
// the core can be re-reset without reloading, or a fresh program can be
// loaded at any time.
//
// Optional feature: define IMEM_BOOT_CHECKSUM_EN to build a running XOR of
// every word accepted since the last clear. Without it load_checksum is tied
// to zero and no checksum register exists.
//
// Ports
//   clock          single clock, rising edge
//   reset_n        asynchronous active-low reset
//   load_start     pulse, begin a new program load (IDLE/RUN/ERROR only)
//   load_valid     host word valid
//   load_ready     sequencer accepts a word this cycle
//   load_data      instruction word from the host
//   load_last      marks the final word of the program
//   run_restart    pulse, re-reset the core without reloading (RUN only)
//   core_reset     active-high reset to the pipeline
//   imem_reset     active-high clear to the instruction memory
//   imem_we        instruction memory write strobe
//   PC_write       instruction memory write address
//   instruction_in instruction memory write data
//   busy           high in every state except IDLE and RUN
//   overflow       sticky, a load ran past the top of the address space
//   load_checksum  running XOR of accepted words (zero when feature is off)
// ---------------------------------------------------------------------------
module imem_boot_sequencer #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int BASE_ADDR    = 0,
  parameter int CLEAR_CYCLES = 2,
  parameter int HOLD_CYCLES  = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load_start,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              run_restart,
  output logic              core_reset,
  output logic              imem_reset,
  output logic              imem_we,
  output logic [ADDR_W-1:0] PC_write,
  output logic [DATA_W-1:0] instruction_in,
  output logic              busy,
  output logic              overflow,
  output logic [DATA_W-1:0] load_checksum
);

  localparam int CNT_MAX = (CLEAR_CYCLES > HOLD_CYCLES) ? CLEAR_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1) + 1;

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_RELEASE,
    S_RUN,
    S_ERROR
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] load_addr;
  logic              accept;
  logic              start_ok;

  // load_ready is registered and only high in LOAD, so accept implies LOAD.
  assign accept   = load_valid && load_ready;
  assign start_ok = load_start &&
                    (state == S_IDLE || state == S_RUN || state == S_ERROR);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      cnt            <= '0;
      load_addr      <= BASE;
      core_reset     <= 1'b1;
      imem_reset     <= 1'b1;
      imem_we        <= 1'b0;
      load_ready     <= 1'b0;
      PC_write       <= '0;
      instruction_in <= '0;
      busy           <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if (start_ok) begin
        // cnt starts at 1 so imem_reset is high for exactly CLEAR_CYCLES cycles.
        state      <= S_CLEAR;
        cnt        <= CNT_W'(1);
        load_addr  <= BASE;
        core_reset <= 1'b1;
        imem_reset <= 1'b1;
        load_ready <= 1'b0;
        busy       <= 1'b1;
        overflow   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            core_reset <= 1'b1;
            imem_reset <= 1'b0;
          end
          S_CLEAR: begin
            if (cnt >= CNT_W'(CLEAR_CYCLES)) begin
              state      <= S_LOAD;
              imem_reset <= 1'b0;
              load_ready <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          // write stage: an accepted word appears on the memory port next cycle
          S_LOAD: begin
            if (accept) begin
              imem_we        <= 1'b1;
              PC_write       <= load_addr;
              instruction_in <= load_data;
              load_addr      <= load_addr + ADDR_W'(1);
              if (load_last) begin
                // cnt starts at 0: the hold is counted after the final write cycle.
                state      <= S_RELEASE;
                cnt        <= '0;
                load_ready <= 1'b0;
              end else if (load_addr == ADDR_LAST) begin
                state      <= S_ERROR;
                overflow   <= 1'b1;
                load_ready <= 1'b0;
              end
            end
          end
          S_RELEASE: begin
            if (cnt >= CNT_W'(HOLD_CYCLES)) begin
              state      <= S_RUN;
              core_reset <= 1'b0;
              busy       <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          S_RUN: begin
            if (run_restart) begin
              // No write precedes a restart, so the current cycle already counts.
              state      <= S_RELEASE;
              cnt        <= CNT_W'(1);
              core_reset <= 1'b1;
              busy       <= 1'b1;
            end
          end
          S_ERROR: begin
            core_reset <= 1'b1;
            load_ready <= 1'b0;
          end
          default: begin
            state      <= S_IDLE;
            core_reset <= 1'b1;
            busy       <= 1'b0;
            load_ready <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef IMEM_BOOT_CHECKSUM_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      load_checksum <= '0;
    end else if (start_ok) begin
      load_checksum <= '0;
    end else if (accept) begin
      load_checksum <= load_checksum ^ load_data;
    end
  end
`else
  assign load_checksum = '0;
`endif

endmodule

// File: tb/tb_imem_boot_sequencer.sv
// ---------------------------------------------------------------------------
// Bench for imem_boot_sequencer. Two instances: the default geometry for the
// load/restart/abort scenarios and a 2-bit address geometry for overflow.
// The reference model tracks expected memory writes (cycle, address, data),
// the XOR checksum and the reset-hold lengths from the behavioural rules.
// ---------------------------------------------------------------------------
module tb_imem_boot_sequencer;

  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int CLR  = 2;
  localparam int HOLD = 4;
  localparam int OAW  = 2;

`ifdef IMEM_BOOT_CHECKSUM_EN
  localparam logic [31:0] CK_MASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] CK_MASK = 32'h0;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic          load_start, load_valid, load_last, run_restart;
  logic [DW-1:0] load_data;
  logic          load_ready, core_reset, imem_reset, imem_we, busy, overflow;
  logic [AW-1:0] PC_write;
  logic [DW-1:0] instruction_in, load_checksum;

  logic           o_start, o_valid, o_last, o_restart;
  logic [DW-1:0]  o_data;
  logic           o_load_ready, o_core_reset, o_imem_reset, o_imem_we, o_busy, o_overflow;
  logic [OAW-1:0] o_pc;
  logic [DW-1:0]  o_instr, o_checksum;

  imem_boot_sequencer #(
    .ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(0), .CLEAR_CYCLES(CLR), .HOLD_CYCLES(HOLD)
  ) dut (
    .clock(clock), .reset_n(reset_n), .load_start(load_start), .load_valid(load_valid),
    .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
    .run_restart(run_restart), .core_reset(core_reset), .imem_reset(imem_reset),
    .imem_we(imem_we), .PC_write(PC_write), .instruction_in(instruction_in),
    .busy(busy), .overflow(overflow), .load_checksum(load_checksum)
  );

  imem_boot_sequencer #(
    .ADDR_W(OAW), .DATA_W(DW), .BASE_ADDR(0), .CLEAR_CYCLES(CLR), .HOLD_CYCLES(HOLD)
  ) dut_o (
    .clock(clock), .reset_n(reset_n), .load_start(o_start), .load_valid(o_valid),
    .load_ready(o_load_ready), .load_data(o_data), .load_last(o_last),
    .run_restart(o_restart), .core_reset(o_core_reset), .imem_reset(o_imem_reset),
    .imem_we(o_imem_we), .PC_write(o_pc), .instruction_in(o_instr),
    .busy(o_busy), .overflow(o_overflow), .load_checksum(o_checksum)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic [15:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         obs_log[$];
  wr_t         obs_log_o[$];
  wr_t         exp_log[$];
  wr_t         mon_w;
  wr_t         mon_wo;
  logic [31:0] prog[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (imem_we) begin
      mon_w.cyc = cyc;
      mon_w.a   = 16'(PC_write);
      mon_w.d   = instruction_in;
      obs_log.push_back(mon_w);
    end
    if (o_imem_we) begin
      mon_wo.cyc = cyc;
      mon_wo.a   = 16'(o_pc);
      mon_wo.d   = o_instr;
      obs_log_o.push_back(mon_wo);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ck_model(input logic [31:0] x);
    return x & CK_MASK;
  endfunction

  task automatic expect_write(input int unsigned c, input logic [15:0] a, input logic [31:0] d);
    wr_t e;
    e.cyc = c;
    e.a   = a;
    e.d   = d;
    exp_log.push_back(e);
  endtask

  task automatic compare_logs(input string tag, input bit other);
    int n;
    n = other ? obs_log_o.size() : obs_log.size();
    check({tag, "_write_count"}, 64'(n), 64'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < n; i++) begin
      wr_t w;
      w = other ? obs_log_o[i] : obs_log[i];
      check({tag, "_write_cycle"}, 64'(w.cyc), 64'(exp_log[i].cyc));
      check({tag, "_write_addr"},  64'(w.a),   64'(exp_log[i].a));
      check({tag, "_write_data"},  64'(w.d),   64'(exp_log[i].d));
    end
    obs_log.delete();
    obs_log_o.delete();
    exp_log.delete();
  endtask

  // mode 0: word every cycle; mode 1: random gaps (with ignored load_start/
  // run_restart in gap cycles); mode 2: valid pattern 1,0,1,1,...
  task automatic load_program(input int mode, input bit also_restart);
    logic [15:0] addr = 16'h0;
    logic [31:0] xs = 32'h0;
    int idx = 0;
    int t = 0;
    int k = 0;
    bit v;
    load_start  = 1'b1;
    run_restart = also_restart;
    step();
    load_start  = 1'b0;
    run_restart = 1'b0;
    check("clear_entry_imem_reset", 64'(imem_reset), 64'(1));
    check("clear_entry_core_reset", 64'(core_reset), 64'(1));
    check("clear_entry_busy",       64'(busy),       64'(1));
    check("clear_entry_ready",      64'(load_ready), 64'(0));
    check("clear_entry_overflow",   64'(overflow),   64'(0));
    check("clear_entry_checksum",   64'(load_checksum), 64'(0));
    step();
    check("clear_second_cycle", 64'(imem_reset), 64'(1));
    step();
    check("clear_done_imem_reset", 64'(imem_reset), 64'(0));
    check("load_ready_high",       64'(load_ready), 64'(1));
    while (idx < prog.size() && t < 200) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = 1'($urandom_range(0, 1));
        default: v = (t != 1);
      endcase
      load_valid  = v;
      load_data   = v ? prog[idx] : $urandom();
      load_last   = v ? (idx == prog.size() - 1) : 1'($urandom_range(0, 1));
      load_start  = !v && mode == 1 && $urandom_range(0, 1) == 1;
      run_restart = !v && mode == 1 && $urandom_range(0, 1) == 1;
      step();
      t++;
      if (v) begin
        expect_write(cyc, addr, prog[idx]);
        xs = xs ^ prog[idx];
        addr = addr + 16'h1;
        idx++;
        check("running_checksum", 64'(load_checksum), 64'(ck_model(xs)));
      end
    end
    load_valid  = 1'b0;
    load_last   = 1'b0;
    load_start  = 1'b0;
    run_restart = 1'b0;
    k = 0;
    do begin
      step();
      k++;
    end while (core_reset && k < 20);
    check("release_hold_length", 64'(k), 64'(HOLD + 1));
    check("run_busy",      64'(busy),       64'(0));
    check("run_ready",     64'(load_ready), 64'(0));
    check("run_imem_we",   64'(imem_we),    64'(0));
    check("hold_pc_write", 64'(PC_write),   64'(addr - 16'h1));
    check("hold_instr",    64'(instruction_in), 64'(prog[prog.size() - 1]));
    check("final_checksum", 64'(load_checksum), 64'(ck_model(xs)));
    compare_logs("load", 1'b0);
  endtask

  initial begin
    logic [15:0] oaddr;
    bit          in_load;
    int          k;
    load_start = 0; load_valid = 0; load_last = 0; run_restart = 0; load_data = '0;
    o_start = 0; o_valid = 0; o_last = 0; o_restart = 0; o_data = '0;

    // reset held for two cycles
    step();
    step();
    check("rst_core_reset", 64'(core_reset), 64'(1));
    check("rst_imem_reset", 64'(imem_reset), 64'(1));
    check("rst_imem_we",    64'(imem_we),    64'(0));
    check("rst_pc_write",   64'(PC_write),   64'(0));
    check("rst_instr",      64'(instruction_in), 64'(0));
    check("rst_ready",      64'(load_ready), 64'(0));
    check("rst_busy",       64'(busy),       64'(0));
    check("rst_overflow",   64'(overflow),   64'(0));
    check("rst_checksum",   64'(load_checksum), 64'(0));
    check("rst_o_imem_reset", 64'(o_imem_reset), 64'(1));
    reset_n = 1'b1;
    #1;
    check("release_before_edge_imem_reset", 64'(imem_reset), 64'(1));
    step();
    check("release_imem_reset", 64'(imem_reset), 64'(0));
    check("release_core_reset", 64'(core_reset), 64'(1));
    check("release_idle_busy",  64'(busy),       64'(0));

    // run_restart outside RUN has no effect
    run_restart = 1'b1;
    step();
    run_restart = 1'b0;
    check("restart_idle_busy",       64'(busy),       64'(0));
    check("restart_idle_core_reset", 64'(core_reset), 64'(1));
    step();
    check("idle_no_write", 64'(obs_log.size()), 64'(0));

    // directed three-word back-to-back load
    prog = '{32'hFFFF_FFFF, 32'hABCB_FFFF, 32'h1234_5678};
    load_program(0, 1'b0);

    // restart from RUN: core re-reset, memory untouched
    run_restart = 1'b1;
    step();
    run_restart = 1'b0;
    check("restart_core_reset", 64'(core_reset), 64'(1));
    check("restart_busy",       64'(busy),       64'(1));
    k = 0;
    do begin
      step();
      k++;
    end while (core_reset && k < 20);
    check("restart_hold_length", 64'(k), 64'(HOLD));
    check("restart_no_write", 64'(obs_log.size()), 64'(0));
    check("restart_pc_hold",  64'(PC_write), 64'(2));

    // backpressure: valid 1,0,1
    prog = '{$urandom(), $urandom()};
    load_program(2, 1'b0);

    // random programs; each starts from RUN with load_start+run_restart together
    for (int r = 0; r < 4; r++) begin
      prog.delete();
      for (int i = 0; i < int'($urandom_range(1, 8)); i++) prog.push_back($urandom());
      load_program((r % 2 == 0) ? 1 : 0, 1'b1);
    end

    // abort a four-word load after two words
    prog = '{$urandom(), $urandom(), $urandom(), $urandom()};
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    step();
    step();
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1;
      load_data  = prog[i];
      load_last  = 1'b0;
      step();
      expect_write(cyc, 16'(i), prog[i]);
    end
    load_valid = 1'b0;
    step();
    reset_n    = 1'b0;
    load_valid = 1'b1;
    load_data  = prog[2];
    #1;
    check("abort_async_imem_we",    64'(imem_we),    64'(0));
    check("abort_async_core_reset", 64'(core_reset), 64'(1));
    check("abort_async_ready",      64'(load_ready), 64'(0));
    check("abort_async_busy",       64'(busy),       64'(0));
    check("abort_async_pc_write",   64'(PC_write),   64'(0));
    step();
    step();
    reset_n = 1'b1;
    step();
    step();
    check("abort_idle_busy",       64'(busy),       64'(0));
    check("abort_idle_core_reset", 64'(core_reset), 64'(1));
    check("abort_idle_ready",      64'(load_ready), 64'(0));
    load_valid = 1'b0;
    compare_logs("abort", 1'b0);

    // overflow on the 2-bit address instance
    o_start = 1'b1;
    step();
    o_start = 1'b0;
    check("ovf_clear_imem_reset", 64'(o_imem_reset), 64'(1));
    step();
    step();
    check("ovf_load_ready", 64'(o_load_ready), 64'(1));
    oaddr   = 16'h0;
    in_load = 1'b1;
    for (int t = 0; t < 5; t++) begin
      o_valid = 1'b1;
      o_data  = $urandom();
      o_last  = 1'b0;
      step();
      if (in_load) begin
        expect_write(cyc, oaddr, o_data);
        if (oaddr == 16'((1 << OAW) - 1)) in_load = 1'b0;
        oaddr = oaddr + 16'h1;
      end
    end
    o_valid = 1'b0;
    check("ovf_flag",       64'(o_overflow),   64'(1));
    check("ovf_ready",      64'(o_load_ready), 64'(0));
    check("ovf_core_reset", 64'(o_core_reset), 64'(1));
    check("ovf_busy",       64'(o_busy),       64'(1));
    compare_logs("ovf", 1'b1);
    o_restart = 1'b1;
    step();
    step();
    step();
    o_restart = 1'b0;
    check("ovf_restart_ignored_core_reset", 64'(o_core_reset), 64'(1));
    check("ovf_restart_ignored_busy",       64'(o_busy),       64'(1));
    check("ovf_sticky",                     64'(o_overflow),   64'(1));
    check("ovf_no_extra_write", 64'(obs_log_o.size()), 64'(0));
    o_start = 1'b1;
    step();
    o_start = 1'b0;
    check("ovf_recover_imem_reset", 64'(o_imem_reset), 64'(1));
    check("ovf_recover_overflow",   64'(o_overflow),   64'(0));
    step();
    step();
    o_valid = 1'b1;
    o_last  = 1'b1;
    o_data  = $urandom();
    step();
    expect_write(cyc, 16'h0, o_data);
    o_valid = 1'b0;
    o_last  = 1'b0;
    k = 0;
    do begin
      step();
      k++;
    end while (o_core_reset && k < 20);
    check("ovf_recover_hold_length", 64'(k), 64'(HOLD + 1));
    check("ovf_recover_busy",        64'(o_busy), 64'(0));
    compare_logs("ovf_recover", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
